// File: rtl/ctrl_rd_embed_if.sv
// Read/write bus bundle for ctrl_rd_embed: IMAGE and SECRET BRAM read ports
// and the stego-byte output FIFO write port.
interface ctrl_rd_embed_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FF_WIDTH   = 8
);
  logic                  image_clk;
  logic [ADDR_WIDTH-1:0] image_addr;
  logic                  image_en;
  logic [DATA_WIDTH-1:0] image_rddata;
  logic                  secret_clk;
  logic [ADDR_WIDTH-1:0] secret_addr;
  logic                  secret_en;
  logic [DATA_WIDTH-1:0] secret_rddata;
  logic                  ff_full;
  logic [FF_WIDTH-1:0]   ff_wr_data;
  logic                  ff_wren;

  modport master (
    output image_clk, image_addr, image_en,
    input  image_rddata,
    output secret_clk, secret_addr, secret_en,
    input  secret_rddata,
    input  ff_full,
    output ff_wr_data, ff_wren
  );

  modport slave (
    input  image_clk, image_addr, image_en,
    output image_rddata,
    input  secret_clk, secret_addr, secret_en,
    output secret_rddata,
    output ff_full,
    input  ff_wr_data, ff_wren
  );
endinterface

// File: rtl/ctrl_rd_embed.sv
// Reads packed IMAGE/SECRET words back from BRAM and writes LSB-embedded
// stego bytes, one per cycle, into the output FIFO.
module ctrl_rd_embed #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int FF_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] image_size,
  input  logic [REG_WIDTH-1:0] secret_size,
  output logic                 finish,
  output logic                 overflow,
  ctrl_rd_embed_if.master      bus
);
  localparam int EW = REG_WIDTH + 3;

  typedef enum logic [3:0] {
    IDLE, RD_IMG, WAIT_IMG, LD_IMG, RD_SEC, WAIT_SEC, LD_SEC, EMBED, FINISH
  } state_t;

  state_t                state, next;
  logic [REG_WIDTH-1:0]  byte_idx, img_word, sec_word, size;
  logic [EW-1:0]         embed_cnt;
  logic [DATA_WIDTH-1:0] img_data, sec_data;

  logic [EW-1:0]         sec_bits, img_ext;
  logic [REG_WIDTH-1:0]  byte_inc;
  logic                  go, in_embed, inc_in_embed;
  logic [7:0]            img_byte, stego;

  assign bus.image_clk  = clk;
  assign bus.secret_clk = clk;

  assign sec_bits     = {secret_size, 3'b000};
  assign img_ext      = EW'(image_size);
  assign go           = start && (image_size != '0);
  assign byte_inc     = byte_idx + 1'b1;
  assign in_embed     = EW'(byte_idx) < embed_cnt;
  assign inc_in_embed = EW'(byte_inc) < embed_cnt;

  // Secret bit index equals the byte index while embedding, so the lane
  // bits of byte_idx select both the image byte and the secret bit.
  assign img_byte = img_data[{byte_idx[1:0], 3'b000} +: 8];
  assign stego    = in_embed ? {img_byte[7:1], sec_data[byte_idx[4:0]]} : img_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_idx  <= '0;
      img_word  <= '0;
      sec_word  <= '0;
      size      <= '0;
      embed_cnt <= '0;
      overflow  <= 1'b0;
      img_data  <= '0;
      sec_data  <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (go) begin
          byte_idx  <= '0;
          img_word  <= '0;
          sec_word  <= '0;
          size      <= image_size;
          embed_cnt <= (sec_bits > img_ext) ? img_ext : sec_bits;
          overflow  <= sec_bits > img_ext;
        end
        WAIT_IMG: img_data <= bus.image_rddata;
        LD_IMG:   img_word <= img_word + 1'b1;
        WAIT_SEC: sec_data <= bus.secret_rddata;
        LD_SEC:   sec_word <= sec_word + 1'b1;
        EMBED:    if (!bus.ff_full) byte_idx <= byte_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    next            = state;
    finish          = 1'b0;
    bus.image_en    = 1'b0;
    bus.image_addr  = '0;
    bus.secret_en   = 1'b0;
    bus.secret_addr = '0;
    bus.ff_wren     = 1'b0;
    bus.ff_wr_data  = '0;
    case (state)
      IDLE: if (go) next = RD_IMG;
      RD_IMG: begin
        bus.image_en   = 1'b1;
        bus.image_addr = ADDR_WIDTH'(img_word) << 2;
        next           = WAIT_IMG;
      end
      WAIT_IMG: next = LD_IMG;
      LD_IMG:   next = (in_embed && byte_idx[4:0] == 5'd0) ? RD_SEC : EMBED;
      RD_SEC: begin
        bus.secret_en   = 1'b1;
        bus.secret_addr = ADDR_WIDTH'(sec_word) << 2;
        next            = WAIT_SEC;
      end
      WAIT_SEC: next = LD_SEC;
      LD_SEC:   next = EMBED;
      EMBED: if (!bus.ff_full) begin
        bus.ff_wren    = 1'b1;
        bus.ff_wr_data = FF_WIDTH'(stego);
        if (byte_inc == size)                          next = FINISH;
        else if (byte_inc[1:0] == 2'd0)                next = RD_IMG;
        else if (inc_in_embed && byte_inc[4:0] == 5'd0) next = RD_SEC;
      end
      FINISH: begin
        finish = 1'b1;
        if (!start) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
endmodule
